uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync.sv | 26 ++
 rtl/uart_rx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: receiver/transmitter state encodings
// and the bit-period helper used by both directions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } uart_tx_state_e;

  // Clock cycles per serial bit (truncating division).
  function automatic int sclk_period(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous input;
// both stages reset to the idle-high line level.
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Two back-to-back flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/[parity]/stop framing, one held byte.
// Even parity bit is present only when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BaudRate     = 9600,
  parameter int DataBitsSize = 8,
  parameter int ClockFreqHz  = 10000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_sig,
  input  logic                    read,
  output logic [DataBitsSize-1:0] read_data,
  output logic                    read_valid,
  output logic                    frame_err,
  output logic                    overrun,
  output logic                    parity_err
);

  localparam int SClkPeriod =
    sclk_period(ClockFreqHz, BaudRate);
  localparam logic [31:0] FullLast =
    32'(SClkPeriod - 1);
  localparam logic [31:0] HalfLast =
    32'(SClkPeriod / 2 - 1);
  localparam logic [3:0] BitLast =
    4'(DataBitsSize - 1);

`ifdef UART_RX_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  localparam int W = DataBitsSize;

  logic           rx_s;
  logic           prev_q;
  uart_rx_state_e state_q, state_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [3:0]     bit_q, bit_d;
  logic [W-1:0]   shift_q, shift_d;
  logic           pbad_q, pbad_d;
  logic           done;
  logic           rd;

  logic [W-1:0]   data_q;
  logic           valid_q;
  logic           ferr_q;
  logic           perr_q;
  logic           ovr_q;

  uart_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_sig),
    .q_o   (rx_s)
  );

  // Frame FSM, counters and shift register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      pbad_q  <= 1'b0;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      pbad_q  <= pbad_d;
      prev_q  <= rx_s;
    end
  end

  // Next-state: sample mid-start, then once per bit period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pbad_d  = pbad_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        pbad_d = 1'b0;
        if (prev_q && !rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FullLast) begin
          cnt_d   = '0;
          shift_d = (shift_q >> 1)
                  | (W'(rx_s) << (W - 1));
          bit_d   = bit_q + 4'd1;
          if (bit_q == BitLast)
            state_d = ParEn ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (cnt_q == FullLast) begin
          cnt_d   = '0;
          pbad_d  = ParEn & ((^shift_q) != rx_s);
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FullLast) begin
          cnt_d   = '0;
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign rd = read && valid_q;

  // Held byte, status flags and consumer handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (done) begin
        data_q  <= shift_q;
        ferr_q  <= !rx_s;
        perr_q  <= pbad_q;
        valid_q <= 1'b1;
        ovr_q   <= (valid_q && !read)
                 || (ovr_q && !rd);
      end else if (rd) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign read_data  = data_q;
  assign read_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign parity_err = ParEn & perr_q;

endmodule
